// File: rtl/pattern_pkg.sv
// Shared types and constants for the pattern lock checker.
package pattern_pkg;

    localparam int PAT_W = 2;

    typedef logic [PAT_W-1:0] pattern_t;

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        LOCKED,
        ERR
    } lock_state_e;

    localparam pattern_t PAT_DEFAULT = 2'b01;

endpackage

// File: rtl/pattern_lock_checker_sat_counter.sv
// Saturating up-counter with a synchronous clear. It holds at all-ones.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    // Count register: clear has priority, and the count stops at the maximum value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pattern_lock_checker.sv
// Pattern lock checker. It compares accepted beats against EXP, locks after
// LOCK_CNT consecutive matches, and sets a sticky error on a miss after lock.
module pattern_lock_checker
    import pattern_pkg::*;
#(
    parameter int       W        = 2,
    parameter pattern_t EXP      = PAT_DEFAULT,
    parameter int       LOCK_CNT = 4,
    parameter int       CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             clear,
    output logic             locked,
    output logic             error,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] mismatch_cnt
);

    localparam int         SW    = $clog2(LOCK_CNT + 1);
    localparam logic [W-1:0] EXP_W = W'(EXP);

    lock_state_e   state;
    lock_state_e   state_nx;
    logic [SW-1:0] streak;
    logic [SW-1:0] streak_nx;
    logic          accept;
    logic          hit;

    assign in_ready = (state != ERR) && !clear;
    assign accept   = in_valid && in_ready;
    assign hit      = (in_data == EXP_W);
    assign locked   = (state == LOCKED);
    assign error    = (state == ERR);

    // State and streak registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            state  <= state_nx;
            streak <= streak_nx;
        end
    end

    // Next-state logic: clear first, then only accepted beats move the FSM.
    always_comb begin
        state_nx  = state;
        streak_nx = streak;
        if (clear) begin
            state_nx  = IDLE;
            streak_nx = '0;
        end else if (accept) begin
            unique case (state)
                IDLE: begin
                    if (hit) begin
                        if (LOCK_CNT == 1) begin
                            state_nx  = LOCKED;
                            streak_nx = '0;
                        end else begin
                            state_nx  = ACQ;
                            streak_nx = SW'(1);
                        end
                    end else begin
                        state_nx  = ACQ;
                        streak_nx = '0;
                    end
                end
                ACQ: begin
                    if (hit) begin
                        if ((int'(streak) + 1) == LOCK_CNT) begin
                            state_nx  = LOCKED;
                            streak_nx = '0;
                        end else begin
                            streak_nx = streak + SW'(1);
                        end
                    end else begin
                        streak_nx = '0;
                    end
                end
                LOCKED: begin
                    if (!hit) begin
                        state_nx = ERR;
                    end
                end
                ERR: begin
                    state_nx = ERR;
                end
                default: begin
                    state_nx  = IDLE;
                    streak_nx = '0;
                end
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept && hit),
        .clr   (clear),
        .q     (match_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mismatch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept && !hit),
        .clr   (clear),
        .q     (mismatch_cnt)
    );

endmodule

// File: tb/tb_pattern_lock_checker.sv
// Testbench for pattern_lock_checker. It drives a table of vectors into two
// instances: the default 8-bit counters and a 2-bit saturating variant.
// Expected results go through a queue and are compared after each edge.
module tb_pattern_lock_checker;
    import pattern_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] in_data;
    logic       clear;

    logic       in_ready,  s_in_ready;
    logic       locked,    s_locked;
    logic       error,     s_error;
    logic [7:0] match_cnt, mismatch_cnt;
    logic [1:0] s_match_cnt, s_mismatch_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       v;
        logic [1:0] d;
        logic       c;
        logic       rdy;
        logic       lk;
        logic       er;
        int         m;
        int         mm;
    } vec_t;

    typedef struct {
        logic lk;
        logic er;
        int   m;
        int   mm;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    pattern_lock_checker #(.W(2), .EXP(PAT_DEFAULT), .LOCK_CNT(4), .CNT_W(8)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .clear        (clear),
        .locked       (locked),
        .error        (error),
        .match_cnt    (match_cnt),
        .mismatch_cnt (mismatch_cnt)
    );

    pattern_lock_checker #(.W(2), .EXP(PAT_DEFAULT), .LOCK_CNT(4), .CNT_W(2)) u_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (s_in_ready),
        .in_data      (in_data),
        .clear        (clear),
        .locked       (s_locked),
        .error        (s_error),
        .match_cnt    (s_match_cnt),
        .mismatch_cnt (s_mismatch_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    // Compare the registered outputs of both instances against one expected record.
    task automatic check_outputs(input exp_t e);
        chk("locked",         int'(locked),         int'(e.lk));
        chk("error",          int'(error),          int'(e.er));
        chk("match_cnt",      int'(match_cnt),      e.m);
        chk("mismatch_cnt",   int'(mismatch_cnt),   e.mm);
        chk("sat_locked",     int'(s_locked),       int'(e.lk));
        chk("sat_error",      int'(s_error),        int'(e.er));
        chk("sat_match_cnt",  int'(s_match_cnt),    sat3(e.m));
        chk("sat_mismatch",   int'(s_mismatch_cnt), sat3(e.mm));
    endtask

    // Drive one cycle, check in_ready before the edge, and check outputs after it.
    task automatic step(input logic v, input logic [1:0] d, input logic c,
                        input logic rdy, input logic lk, input logic er,
                        input int m, input int mm);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        clear    = c;
        #1;
        chk("in_ready",     int'(in_ready),   int'(rdy));
        chk("sat_in_ready", int'(s_in_ready), int'(rdy));
        e.lk = lk; e.er = er; e.m = m; e.mm = mm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard: queue empty, expected 1 entry");
        end else begin
            check_outputs(sb.pop_front());
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 2'b00;
        clear    = 1'b0;

        // Outputs during reset, before any clock edge.
        #2;
        chk("rst_locked",   int'(locked),       0);
        chk("rst_error",    int'(error),        0);
        chk("rst_match",    int'(match_cnt),    0);
        chk("rst_mismatch", int'(mismatch_cnt), 0);
        chk("rst_ready",    int'(in_ready),     1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        //            v   d     c     rdy   lk    er    m  mm
        // Lock on four hits (one idle cycle in between), then clear.
        tbl.push_back('{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0});
        tbl.push_back('{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0});
        tbl.push_back('{1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0});
        tbl.push_back('{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 3, 0});
        tbl.push_back('{1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 4, 0});
        tbl.push_back('{1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 5, 0});
        tbl.push_back('{1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0});
        // A miss in the middle restarts the streak: 01,01,01,10,01,01,01,01.
        tbl.push_back('{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0});
        tbl.push_back('{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0});
        tbl.push_back('{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 3, 0});
        tbl.push_back('{1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1});
        tbl.push_back('{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 4, 1});
        tbl.push_back('{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 5, 1});
        tbl.push_back('{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 6, 1});
        tbl.push_back('{1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 7, 1});
        // Clear, lock again, then a miss after lock goes to ERR, where beats are dropped.
        tbl.push_back('{1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0});
        tbl.push_back('{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0});
        tbl.push_back('{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0});
        tbl.push_back('{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 3, 0});
        tbl.push_back('{1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 4, 0});
        tbl.push_back('{1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 4, 1});
        tbl.push_back('{1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1});
        tbl.push_back('{1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1});
        // Clear from ERR with in_valid high: the beat is dropped and everything returns to zero.
        tbl.push_back('{1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0});
        tbl.push_back('{1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1});
        tbl.push_back('{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1});
        tbl.push_back('{1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1});

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].rdy,
                 tbl[i].lk, tbl[i].er, tbl[i].m, tbl[i].mm);
        end

        // Asynchronous reset mid-ACQ with streak=2, away from any clock edge.
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0);
        step(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_match",    int'(match_cnt),   0);
        chk("async_sat",      int'(s_match_cnt), 0);
        chk("async_locked",   int'(locked),      0);
        chk("async_ready",    int'(in_ready),    1);
        @(negedge clk);
        rst_n = 1'b1;
        // After release, four fresh hits are needed to lock again.
        step(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0);
        step(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0);
        step(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 3, 0);
        step(1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 4, 0);
        step(1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 5, 0);

        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_lock_checker.md
Name: pattern_lock_checker

Overview:
- Downstream consumer of a parameterised pattern-driving instance, such as a dut whose output is a constant pattern parameter (e.g. P = 2'b01).
- Samples a W-bit word stream via valid/ready and compares each accepted beat against the expected pattern parameter EXP.
- Declares lock after LOCK_CNT consecutive matches and flags a sticky error on any mismatch after lock.
- Exposes saturating match/mismatch counters for the top level.

Parameters:
- W, 2, pattern word width.
- EXP, 2'b01 (type pattern_t), expected pattern; passed as a pattern/struct-typed parameter from the instantiating module.
- LOCK_CNT, 4, consecutive matches required to enter LOCKED; legal range 1..2**CNT_W-1.
- CNT_W, 8, width of the statistics counters.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  beat valid.
- in_ready  output  1  beat accept; a beat is accepted when in_valid && in_ready at a rising edge.
- in_data  input  W  pattern word, e.g. top-level o.
- clear  input  1  synchronous clear of state, flags and counters.
- locked  output  1  high while the FSM is in LOCKED.
- error  output  1  sticky; high while the FSM is in ERR.
- match_cnt  output  CNT_W  accepted beats equal to EXP, saturating.
- mismatch_cnt  output  CNT_W  accepted beats not equal to EXP, saturating.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, streak=0, match_cnt=0, mismatch_cnt=0, locked=0, error=0. in_ready is combinational and therefore 1 during and after reset.
- in_ready = (state != ERR) && !clear. No beat is accepted in the clear cycle or while in ERR.
- Compare is combinational on accepted beats: hit = (in_data == EXP), full W-bit equality, no masking.
- All state, counter and flag updates take effect at the edge that accepts the beat; outputs are registered, so latency is one cycle from acceptance to output.
- FSM states: IDLE, ACQ, LOCKED, ERR.
  - IDLE: on accept, go to ACQ. streak = hit ? 1 : 0. If hit and LOCK_CNT==1, go directly to LOCKED.
  - ACQ: on hit, streak+1; when streak+1 == LOCK_CNT, go to LOCKED and set streak=0. On a miss, streak=0 and stay in ACQ.
  - LOCKED: hit keeps LOCKED. A miss goes to ERR.
  - ERR: absorbing; leaves only on clear or reset.
- Counters: match_cnt increments on an accepted hit and mismatch_cnt on an accepted miss, in every state. Both saturate at 2**CNT_W-1; no wrap.
- streak width is $clog2(LOCK_CNT+1). It never exceeds LOCK_CNT-1 in ACQ.
- clear (any state): next state IDLE, streak, counters and flags all 0. clear has priority over any concurrent in_valid; that beat is not accepted because in_ready is 0.
- in_valid low: no state or counter change.
- Reset asserted mid-stream: immediate return to reset values; the partial streak is discarded.
- The upstream is not required to hold data stable while in_ready is low (ERR or clear); dropped beats are not counted.

Decomposition:
- Shared package pattern_pkg holds:
  - localparam PAT_W = 2.
  - typedef logic [PAT_W-1:0] pattern_t.
  - typedef enum logic [1:0] {IDLE, ACQ, LOCKED, ERR} lock_state_e.
  - Default pattern constant PAT_DEFAULT = 2'b01.
- One sub-module, sat_counter (parameter CNT_W; inputs inc and clr; output q), instantiated twice for the match and mismatch counters.
- FSM and compare logic stay in the top block.

Test Plan:
- Reset then 4 accepted beats of 2'b01 (EXP=2'b01, LOCK_CNT=4) -> locked rises 1 cycle after the 4th beat; match_cnt=4, mismatch_cnt=0, error=0.
- Beats 01,01,01,10,01,01,01,01 -> the miss resets the streak; locked rises only after the 8th beat; match_cnt=7, mismatch_cnt=1, error=0.
- Lock with 4×01, then one 11 -> error=1, locked=0, in_ready=0 next cycle; further beats are not counted (mismatch_cnt stays 1).
- In ERR, assert clear for 1 cycle with in_valid=1 -> beat not accepted; next cycle state=IDLE, all counters 0, in_ready=1.
- CNT_W=2, 5 accepted hits -> match_cnt saturates at 3 and holds.
- Assert rst_n low asynchronously mid-ACQ (streak=2) -> outputs clear without a clock edge; after release, 4 hits are again needed to lock.
